// File: rtl/pong_match_ctrl.sv
// Pong match controller: sequences a match through idle, serve delay, live
// play, point flash, pause and game-over, and owns both player scores.
// All outputs are registered; a state change shows up one cycle after the
// input that caused it.
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 11,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_run,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic               flash,
  output logic [2:0]         state_o
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_POINT     = 3'd3,
    S_PAUSED    = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  state_t           state;
  state_t           ret_state;   // where a pause edge in PAUSED returns to
  logic [CNT_W-1:0] frame_cnt;
  logic             start_prev;
  logic             pause_prev;
  logic             start_edge;
  logic             pause_edge;

  // Previous-value registers reset high, so a button held through reset
  // does not register as a press once reset drops.
  assign start_edge = start_btn & ~start_prev;
  assign pause_edge = pause_btn & ~pause_prev;
  assign state_o    = state;

  // Match sequencer with registered outputs and frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ret_state  <= S_SERVE;
      frame_cnt  <= '0;
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
      score1     <= '0;
      score2     <= '0;
      winner     <= 2'b00;
      ball_run   <= 1'b0;
      ball_reset <= 1'b0;
      serve_dir  <= 1'b0;
      flash      <= 1'b0;
    end else begin
      start_prev <= start_btn;
      pause_prev <= pause_btn;
      ball_reset <= 1'b0;

      case (state)
        // Start (or restart after a win) clears the match and serves right.
        S_IDLE, S_GAME_OVER: begin
          if (start_edge) begin
            score1     <= '0;
            score2     <= '0;
            winner     <= 2'b00;
            serve_dir  <= 1'b1;
            ball_reset <= 1'b1;
            frame_cnt  <= '0;
            ball_run   <= 1'b0;
            flash      <= 1'b0;
            state      <= S_SERVE;
          end
        end

        // Hold the ball for SERVE_FRAMES ticks; pause takes priority over a tick.
        S_SERVE: begin
          if (pause_edge) begin
            ret_state <= S_SERVE;
            state     <= S_PAUSED;
          end else if (frame_tick) begin
            if (frame_cnt == SERVE_LAST) begin
              ball_run <= 1'b1;
              state    <= S_PLAY;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end

        // Live play: a miss always beats a same-cycle pause press.
        S_PLAY: begin
          if (miss_left && miss_right) begin
            ball_reset <= 1'b1;
            ball_run   <= 1'b0;
            frame_cnt  <= '0;
            state      <= S_SERVE;
          end else if (miss_right) begin
            score1     <= score1 + SCORE_W'(1);
            serve_dir  <= 1'b1;
            ball_reset <= 1'b1;
            ball_run   <= 1'b0;
            flash      <= 1'b1;
            frame_cnt  <= '0;
            state      <= S_POINT;
          end else if (miss_left) begin
            score2     <= score2 + SCORE_W'(1);
            serve_dir  <= 1'b0;
            ball_reset <= 1'b1;
            ball_run   <= 1'b0;
            flash      <= 1'b1;
            frame_cnt  <= '0;
            state      <= S_POINT;
          end else if (pause_edge) begin
            ret_state <= S_PLAY;
            ball_run  <= 1'b0;
            state     <= S_PAUSED;
          end
        end

        // Flash the point, then either serve again or declare the winner.
        S_POINT: begin
          if (frame_tick) begin
            if (frame_cnt == POINT_LAST) begin
              flash <= 1'b0;
              if (score1 == WIN_VAL) begin
                winner <= 2'b01;
                state  <= S_GAME_OVER;
              end else if (score2 == WIN_VAL) begin
                winner <= 2'b10;
                state  <= S_GAME_OVER;
              end else begin
                frame_cnt <= '0;
                state     <= S_SERVE;
              end
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end

        // Everything frozen; only a pause press resumes, counter intact.
        S_PAUSED: begin
          if (pause_edge) begin
            ball_run <= (ret_state == S_PLAY);
            state    <= ret_state;
          end
        end

        default: begin
          ball_run <= 1'b0;
          flash    <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Parametrised match controller for the VGA pong game. It sits between the ball/paddle logic and the seven-segment score display. It sequences a match through idle, serve delay, live play, point display, pause and game-over, and owns both player scores. It generalises the fixed free-running scoring with a configurable win threshold, frame-timed serve and point intervals, and pause/restart control.

Parameters:
WIN_SCORE, 11, points needed to win; must satisfy WIN_SCORE < 2**SCORE_W
SCORE_W, 4, width of each score output
SERVE_FRAMES, 60, frame ticks the ball is held before play resumes
POINT_FRAMES, 30, frame ticks the point-flash state lasts

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
frame_tick  input  1  one-cycle pulse per VGA frame (start of vertical blank)
start_btn  input  1  level, active-high; rising edge starts or restarts a match
pause_btn  input  1  level, active-high; rising edge toggles pause
miss_left  input  1  pulse: ball passed the left edge (point to player 2)
miss_right  input  1  pulse: ball passed the right edge (point to player 1)
ball_run  output  1  high only in PLAY; enables ball motion
ball_reset  output  1  one-cycle pulse; recentre the ball
serve_dir  output  1  0 = serve toward left player, 1 = toward right player
score1  output  SCORE_W  player 1 (left) score
score2  output  SCORE_W  player 2 (right) score
winner  output  2  00 none, 01 player 1, 10 player 2
flash  output  1  high throughout POINT
state_o  output  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSED=4, GAME_OVER=5

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: state IDLE, scores 0, winner 00, ball_run 0, ball_reset 0, serve_dir 0, flash 0, frame counter 0.
- Edge detect: the previous-value registers for start_btn and pause_btn reset to 1. A button held through reset therefore produces no edge. Edge = current & ~previous.
- All outputs are registered. A state change is visible the cycle after the triggering input.
- Frame counter:
  - Cleared on entry to SERVE and POINT.
  - Increments only on frame_tick.
  - Width is $clog2(max(SERVE_FRAMES,POINT_FRAMES)+1).
- IDLE:
  - A start edge clears scores and winner, sets serve_dir=1, pulses ball_reset, and goes to SERVE.
  - A pause edge is ignored.
- SERVE:
  - ball_run=0.
  - On the frame_tick where counter == SERVE_FRAMES-1, go to PLAY.
  - A pause edge goes to PAUSED with return state SERVE; the counter is held.
- PLAY:
  - ball_run=1.
  - miss_right alone: score1 += 1, serve_dir=1, go to POINT, pulse ball_reset.
  - miss_left alone: score2 += 1, serve_dir=0, go to POINT, pulse ball_reset.
  - Both misses in the same cycle: no score change, serve_dir unchanged, pulse ball_reset, go to SERVE.
  - A pause edge in the same cycle as a miss: the miss wins and the pause is ignored.
  - Otherwise a pause edge goes to PAUSED with return state PLAY.
- POINT:
  - flash=1, ball_run=0.
  - On the frame_tick where counter == POINT_FRAMES-1:
    - If either score == WIN_SCORE, set winner and go to GAME_OVER.
    - Otherwise go to SERVE.
  - Pause edges are ignored.
- PAUSED:
  - ball_run=0; counter and scores frozen.
  - A pause edge returns to the saved state with the counter intact. No ball_reset pulse.
  - Start edges and misses are ignored.
- GAME_OVER:
  - ball_run=0; scores and winner held.
  - A start edge behaves exactly as the start edge in IDLE.
- Misses outside PLAY are ignored.
- Scores never exceed WIN_SCORE. Increments happen only in PLAY, and reaching WIN_SCORE always leads through POINT to GAME_OVER.
- Reset asserted in any state overrides all inputs in that cycle and returns the block to the reset values.

Test Plan:
- Reset, then start edge, then 60 frame_ticks -> ball_reset pulses 1 cycle after the edge; state_o 0→1; PLAY (2) reached on the 60th tick; ball_run=1.
- In PLAY, pulse miss_right -> score1=1, serve_dir=1, flash=1 for 30 ticks, then state SERVE; a second miss_right during POINT does not change score1.
- In PLAY, miss_left and miss_right in the same cycle -> scores unchanged, ball_reset pulse, state SERVE.
- In SERVE after 20 ticks, pause edge, 100 ticks, pause edge -> state 4 then 1; PLAY entered exactly 40 ticks later; miss and start pulses while paused have no effect.
- Drive 11 miss_left pulses with WIN_SCORE=11 -> score2=11, winner=10, state 5 after the final POINT; a start edge -> scores 0, winner 00, state SERVE.
- Hold start_btn high through reset and release of reset -> state remains IDLE until start_btn drops and rises again.
